// File: rtl/bch_arbiter.sv
// Round-robin arbiter sharing one BCH engine between the encoder and decoder paths.
// All outputs are registered; a WAIT watchdog raises a sticky timeout if the engine never answers.
module bch_arbiter #(
  parameter int MODE_BITS    = 3,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic [1:0]           I_req,
  output logic [1:0]           O_gnt,
  output logic                 O_bch_start,
  output logic [MODE_BITS-1:0] O_bch_mode,
  input  logic                 I_bch_ready,
  output logic [1:0]           O_done,
  output logic                 O_busy,
  output logic                 O_timeout,
  input  logic                 I_clr
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [MODE_BITS-1:0] MODE_ENC = MODE_BITS'(1);
  localparam logic [MODE_BITS-1:0] MODE_DEC = MODE_BITS'(2);

  state_t                  state_q, state_d;
  logic [1:0]              gnt_q, gnt_d;
  logic                    start_q, start_d;
  logic [MODE_BITS-1:0]    mode_q, mode_d;
  logic [1:0]              done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;
  logic                    last_q, last_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
  logic                    win_idx;

  // With both requesting, the index that was not served last wins.
  assign win_idx = (I_req == 2'b11) ? ~last_q : I_req[1];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    start_d   = 1'b0;
    mode_d    = mode_q;
    done_d    = 2'b00;
    busy_d    = busy_q;
    timeout_d = timeout_q & ~I_clr;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = 2'b00;
        mode_d = '0;
        busy_d = 1'b0;
        if (I_req != 2'b00) begin
          gnt_d   = win_idx ? 2'b10 : 2'b01;
          mode_d  = win_idx ? MODE_DEC : MODE_ENC;
          start_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ready takes precedence over an expiring watchdog in the same cycle.
        if (I_bch_ready) begin
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          mode_d  = '0;
          last_d  = gnt_q[1];
          state_d = ST_DONE;
        end else if (&cnt_q) begin
          timeout_d = 1'b1;
          gnt_d     = 2'b00;
          mode_d    = '0;
          last_d    = gnt_q[1];
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_BITS'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 2'b00;
      start_q   <= 1'b0;
      mode_q    <= '0;
      done_q    <= 2'b00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      start_q   <= start_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign O_gnt       = gnt_q;
  assign O_bch_start = start_q;
  assign O_bch_mode  = mode_q;
  assign O_done      = done_q;
  assign O_busy      = busy_q;
  assign O_timeout   = timeout_q;

endmodule
